// File: rtl/usb_desc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_desc_pkg                                                 |
// | Description : Shared definitions for the EP0 descriptor server: descriptor |
// |               type codes, ROM window table, FSM state encoding and the     |
// |               device-qualifier / other-speed patch constants.              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package usb_desc_pkg;

    localparam logic [7:0] c_type_device      = 8'h01;
    localparam logic [7:0] c_type_config      = 8'h02;
    localparam logic [7:0] c_type_string      = 8'h03;
    localparam logic [7:0] c_type_qualifier   = 8'h06;
    localparam logic [7:0] c_type_other_speed = 8'h07;

    localparam int c_device_base      = 0;
    localparam int c_device_len       = 18;
    localparam int c_config_base      = 18;
    localparam int c_config_len       = 67;
    localparam int c_num_string_slots = 4;
    localparam int c_qual_len         = 10;

    // Absolute ROM addresses rewritten when the config window is served as
    // an other-speed configuration.
    localparam int c_osc_type_addr  = 19;
    localparam int c_osc_bulk0_lo   = 75;
    localparam int c_osc_bulk0_hi   = 76;
    localparam int c_osc_bulk1_lo   = 82;
    localparam int c_osc_bulk1_hi   = 83;

    // Bulk wMaxPacketSize per speed (little-endian on the wire).
    localparam logic [15:0] c_bulk_mps_fs = 16'h0040;
    localparam logic [15:0] c_bulk_mps_hs = 16'h0200;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        STREAM = 3'd2,
        ZLP    = 3'd3,
        DONE   = 3'd4
    } state_t;

    function automatic int string_base(input logic [1:0] idx);
        case (idx)
            2'd0:    return 85;
            2'd1:    return 89;
            2'd2:    return 119;
            default: return 149;
        endcase
    endfunction

    function automatic int string_len(input logic [1:0] idx);
        case (idx)
            2'd0:    return 4;
            2'd1:    return 30;
            2'd2:    return 30;
            default: return 14;
        endcase
    endfunction

    // Synthesized device-qualifier descriptor; byte 7 is bMaxPacketSize0 of
    // the other speed.
    function automatic logic [7:0] qual_byte(input logic [3:0] offset,
                                             input logic [7:0] other_mps);
        logic [7:0] b;
        case (offset)
            4'd0:    b = 8'h0A;
            4'd1:    b = 8'h06;
            4'd3:    b = 8'h02;
            4'd4:    b = 8'h02;
            4'd7:    b = other_mps;
            4'd8:    b = 8'h01;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/usb_desc_lookup.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_desc_lookup                                              |
// | Description : Combinational resolver from descriptor type/index to a ROM   |
// |               window {base, dlen} plus data-source selects.                |
// |               Build option USB_DESC_QUALIFIER_EN adds types 6 and 7.       |
// | Ports       : i_desc_type/i_desc_index -> o_base, o_dlen, o_supported,     |
// |               o_src_qual (internal qualifier bytes), o_patch_osc.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module usb_desc_lookup
    import usb_desc_pkg::*;
#(
    parameter int ROM_AW      = 8,
    parameter int NUM_STRINGS = 4
) (
    input  logic [7:0]        i_desc_type,
    input  logic [7:0]        i_desc_index,
    output logic [ROM_AW-1:0] o_base,
    output logic [15:0]       o_dlen,
    output logic              o_supported,
    output logic              o_src_qual,
    output logic              o_patch_osc
);

    // Only as many strings as the table actually holds can be served.
    localparam int c_strings = (NUM_STRINGS < c_num_string_slots) ? NUM_STRINGS
                                                                  : c_num_string_slots;

    always_comb begin
        o_base      = '0;
        o_dlen      = '0;
        o_supported = 1'b0;
        o_src_qual  = 1'b0;
        o_patch_osc = 1'b0;
        case (i_desc_type)
            c_type_device: begin
                o_base      = ROM_AW'(c_device_base);
                o_dlen      = 16'(c_device_len);
                o_supported = 1'b1;
            end
            c_type_config: begin
                if (i_desc_index == 8'd0) begin
                    o_base      = ROM_AW'(c_config_base);
                    o_dlen      = 16'(c_config_len);
                    o_supported = 1'b1;
                end
            end
            c_type_string: begin
                if (int'({24'd0, i_desc_index}) < c_strings) begin
                    o_base      = ROM_AW'(string_base(i_desc_index[1:0]));
                    o_dlen      = 16'(string_len(i_desc_index[1:0]));
                    o_supported = 1'b1;
                end
            end
`ifdef USB_DESC_QUALIFIER_EN
            c_type_qualifier: begin
                o_dlen      = 16'(c_qual_len);
                o_supported = 1'b1;
                o_src_qual  = 1'b1;
            end
            c_type_other_speed: begin
                if (i_desc_index == 8'd0) begin
                    o_base      = ROM_AW'(c_config_base);
                    o_dlen      = 16'(c_config_len);
                    o_supported = 1'b1;
                    o_patch_osc = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/usb_desc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : usb_desc_engine                                              |
// | Description : Sequential EP0 GET_DESCRIPTOR server. Resolves a request to  |
// |               a ROM window, streams bytes truncated to wLength, split into |
// |               max-packet-size packets, with zero-length-packet insertion.  |
// |               Build option USB_DESC_QUALIFIER_EN serves types 6 and 7.     |
// | Ports       : clk_i, rst_i (sync, active-low); request side req_*, hs_i,   |
// |               abort_i; ROM side rom_addr_o/rom_data_i (combinational ROM); |
// |               stream side tx_* (valid/ready); done_o, stall_o pulses.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module usb_desc_engine
    import usb_desc_pkg::*;
#(
    parameter int ROM_AW      = 8,
    parameter int NUM_STRINGS = 4,
    parameter int EP0_MPS_FS  = 8,
    parameter int EP0_MPS_HS  = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              hs_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [7:0]        req_type_i,
    input  logic [7:0]        req_index_i,
    input  logic [15:0]       req_length_i,
    input  logic              abort_i,
    output logic [ROM_AW-1:0] rom_addr_o,
    input  logic [7:0]        rom_data_i,
    output logic [7:0]        tx_data_o,
    output logic              tx_valid_o,
    output logic              tx_last_o,
    output logic              tx_zlp_o,
    input  logic              tx_ready_i,
    output logic              done_o,
    output logic              stall_o
);

    localparam logic [6:0] c_mps_fs = 7'(EP0_MPS_FS);
    localparam logic [6:0] c_mps_hs = 7'(EP0_MPS_HS);

    state_t            r_state, w_next;
    logic [7:0]        r_type, r_index;
    logic [15:0]       r_length, r_remain;
    logic              r_hs, r_short, r_src_qual, r_patch_osc;
    logic [6:0]        r_mps, r_pkt_cnt;
    logic [ROM_AW-1:0] r_addr;

    logic [ROM_AW-1:0] w_base;
    logic [15:0]       w_dlen, w_min;
    logic              w_supported, w_src_qual, w_patch_osc;
    logic              w_accept, w_fire, w_full, w_last;
    logic [7:0]        w_other_mps, w_osc_lo, w_osc_hi, w_data;

    usb_desc_lookup #(
        .ROM_AW      (ROM_AW),
        .NUM_STRINGS (NUM_STRINGS)
    ) u_lookup (
        .i_desc_type  (r_type),
        .i_desc_index (r_index),
        .o_base       (w_base),
        .o_dlen       (w_dlen),
        .o_supported  (w_supported),
        .o_src_qual   (w_src_qual),
        .o_patch_osc  (w_patch_osc)
    );

    assign w_min  = (r_length < w_dlen) ? r_length : w_dlen;
    assign w_full = (r_pkt_cnt == r_mps - 7'd1);
    assign w_last = w_full || (r_remain == 16'd1);

    // "Other speed" values are the opposite of the speed latched at accept.
    assign w_other_mps = r_hs ? 8'(EP0_MPS_FS) : 8'(EP0_MPS_HS);
    assign w_osc_lo    = r_hs ? c_bulk_mps_fs[7:0]  : c_bulk_mps_hs[7:0];
    assign w_osc_hi    = r_hs ? c_bulk_mps_fs[15:8] : c_bulk_mps_hs[15:8];

    always_comb begin
        w_data = rom_data_i;
        if (r_src_qual) begin
            w_data = qual_byte(r_addr[3:0], w_other_mps);
        end else if (r_patch_osc) begin
            if (r_addr == ROM_AW'(c_osc_type_addr)) begin
                w_data = c_type_other_speed;
            end else if (r_addr == ROM_AW'(c_osc_bulk0_lo) || r_addr == ROM_AW'(c_osc_bulk1_lo)) begin
                w_data = w_osc_lo;
            end else if (r_addr == ROM_AW'(c_osc_bulk0_hi) || r_addr == ROM_AW'(c_osc_bulk1_hi)) begin
                w_data = w_osc_hi;
            end
        end
    end

    assign rom_addr_o = r_addr;
    assign tx_data_o  = (r_state == STREAM) ? w_data : 8'h00;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort outranks every transition, including a same-cycle handshake.
    always_comb begin
        w_next      = r_state;
        req_ready_o = 1'b0;
        tx_valid_o  = 1'b0;
        tx_last_o   = 1'b0;
        tx_zlp_o    = 1'b0;
        done_o      = 1'b0;
        stall_o     = 1'b0;
        w_accept    = 1'b0;
        w_fire      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready_o = !abort_i;
                if (req_valid_i && !abort_i) begin
                    w_accept = 1'b1;
                    w_next   = LOOKUP;
                end
            end
            LOOKUP: begin
                if (abort_i) begin
                    w_next = IDLE;
                end else if (!w_supported) begin
                    stall_o = 1'b1;
                    w_next  = IDLE;
                end else if (w_min == 16'd0) begin
                    w_next = ZLP;
                end else begin
                    w_next = STREAM;
                end
            end
            STREAM: begin
                tx_valid_o = 1'b1;
                tx_last_o  = w_last;
                if (abort_i) begin
                    w_next = IDLE;
                end else if (tx_ready_i) begin
                    w_fire = 1'b1;
                    if (r_remain == 16'd1) begin
                        // Full final packet with the host asking for more
                        // needs a ZLP to terminate the transfer.
                        w_next = (w_full && r_short) ? ZLP : DONE;
                    end
                end
            end
            ZLP: begin
                tx_valid_o = 1'b1;
                tx_last_o  = 1'b1;
                tx_zlp_o   = 1'b1;
                if (abort_i) begin
                    w_next = IDLE;
                end else if (tx_ready_i) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                done_o = !abort_i;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_type      <= '0;
            r_index     <= '0;
            r_length    <= '0;
            r_hs        <= 1'b0;
            r_mps       <= c_mps_fs;
            r_addr      <= '0;
            r_remain    <= '0;
            r_pkt_cnt   <= '0;
            r_short     <= 1'b0;
            r_src_qual  <= 1'b0;
            r_patch_osc <= 1'b0;
        end else begin
            if (w_accept) begin
                r_type   <= req_type_i;
                r_index  <= req_index_i;
                r_length <= req_length_i;
                r_hs     <= hs_i;
                r_mps    <= hs_i ? c_mps_hs : c_mps_fs;
            end
            if (r_state == LOOKUP) begin
                r_addr      <= w_base;
                r_remain    <= w_min;
                r_pkt_cnt   <= '0;
                r_short     <= (w_min < r_length);
                r_src_qual  <= w_src_qual;
                r_patch_osc <= w_patch_osc;
            end
            if (w_fire) begin
                r_addr    <= r_addr + ROM_AW'(1);
                r_remain  <= r_remain - 16'd1;
                r_pkt_cnt <= w_last ? 7'd0 : r_pkt_cnt + 7'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_usb_desc_engine.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_usb_desc_engine                                           |
// | Description : Self-checking bench for usb_desc_engine. Two instances: the  |
// |               default build (EP0_MPS_FS=8) and one with EP0_MPS_FS=2 so    |
// |               short full packets and ZLPs are reachable. Expected beats    |
// |               come from a descriptor-table model of the transfer rules.    |
// |               Honours USB_DESC_QUALIFIER_EN like the design.               |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_usb_desc_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        hs = 1'b0, req_valid = 1'b0, abort = 1'b0, tx_ready = 1'b0, sel = 1'b0;
    logic [7:0]  req_type = '0, req_index = '0;
    logic [15:0] req_length = '0;
    logic [7:0]  rom [256];

    logic       a_req_ready, a_tx_valid, a_tx_last, a_tx_zlp, a_done, a_stall;
    logic [7:0] a_rom_addr, a_rom_data, a_tx_data;
    logic       b_req_ready, b_tx_valid, b_tx_last, b_tx_zlp, b_done, b_stall;
    logic [7:0] b_rom_addr, b_rom_data, b_tx_data;
    logic       a_req_valid, b_req_valid, a_tx_ready, b_tx_ready;

    assign a_rom_data  = rom[a_rom_addr];
    assign b_rom_data  = rom[b_rom_addr];
    assign a_req_valid = req_valid && !sel;
    assign b_req_valid = req_valid && sel;
    assign a_tx_ready  = tx_ready && !sel;
    assign b_tx_ready  = tx_ready && sel;

    usb_desc_engine u_dut_a (
        .clk_i(clk), .rst_i(rst_n), .hs_i(hs), .req_valid_i(a_req_valid),
        .req_ready_o(a_req_ready), .req_type_i(req_type), .req_index_i(req_index),
        .req_length_i(req_length), .abort_i(abort), .rom_addr_o(a_rom_addr),
        .rom_data_i(a_rom_data), .tx_data_o(a_tx_data), .tx_valid_o(a_tx_valid),
        .tx_last_o(a_tx_last), .tx_zlp_o(a_tx_zlp), .tx_ready_i(a_tx_ready),
        .done_o(a_done), .stall_o(a_stall)
    );

    usb_desc_engine #(.EP0_MPS_FS(2)) u_dut_b (
        .clk_i(clk), .rst_i(rst_n), .hs_i(hs), .req_valid_i(b_req_valid),
        .req_ready_o(b_req_ready), .req_type_i(req_type), .req_index_i(req_index),
        .req_length_i(req_length), .abort_i(abort), .rom_addr_o(b_rom_addr),
        .rom_data_i(b_rom_data), .tx_data_o(b_tx_data), .tx_valid_o(b_tx_valid),
        .tx_last_o(b_tx_last), .tx_zlp_o(b_tx_zlp), .tx_ready_i(b_tx_ready),
        .done_o(b_done), .stall_o(b_stall)
    );

    wire       m_req_ready = sel ? b_req_ready : a_req_ready;
    wire       m_tx_valid  = sel ? b_tx_valid  : a_tx_valid;
    wire       m_tx_last   = sel ? b_tx_last   : a_tx_last;
    wire       m_tx_zlp    = sel ? b_tx_zlp    : a_tx_zlp;
    wire       m_done      = sel ? b_done      : a_done;
    wire       m_stall     = sel ? b_stall     : a_stall;
    wire [7:0] m_tx_data   = sel ? b_tx_data   : a_tx_data;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [7:0] d;
        logic       last;
        logic       zlp;
    } beat_t;
    beat_t exp_q[$];

    // Reference: descriptor table and transfer rules, expressed as a beat list.
    task automatic build_expect(input bit s, input bit h, input logic [7:0] t,
                                input logic [7:0] i, input logic [15:0] l, output bit st);
        int base, dlen, mps, n;
        bit ok;
        logic [7:0] b;
        logic [7:0] qual [10];
        beat_t bt;
        exp_q.delete();
        ok = 1'b1; base = 0; dlen = 0;
        mps = h ? 64 : (s ? 2 : 8);
        case (t)
            8'd1: begin base = 0; dlen = 18; end
            8'd2: if (i == 8'd0) begin base = 18; dlen = 67; end else ok = 1'b0;
            8'd3: case (i)
                      8'd0: begin base = 85;  dlen = 4;  end
                      8'd1: begin base = 89;  dlen = 30; end
                      8'd2: begin base = 119; dlen = 30; end
                      8'd3: begin base = 149; dlen = 14; end
                      default: ok = 1'b0;
                  endcase
`ifdef USB_DESC_QUALIFIER_EN
            8'd6: begin base = 0; dlen = 10; end
            8'd7: if (i == 8'd0) begin base = 18; dlen = 67; end else ok = 1'b0;
`endif
            default: ok = 1'b0;
        endcase
        st = !ok;
        if (!ok) return;
        qual[0] = 8'h0A; qual[1] = 8'h06; qual[2] = 8'h00; qual[3] = 8'h02; qual[4] = 8'h02;
        qual[5] = 8'h00; qual[6] = 8'h00; qual[8] = 8'h01; qual[9] = 8'h00;
        qual[7] = h ? (s ? 8'd2 : 8'd8) : 8'd64;
        n = (int'(l) < dlen) ? int'(l) : dlen;
        for (int k = 0; k < n; k++) begin
            if (t == 8'd6) begin
                b = qual[k];
            end else begin
                b = rom[base + k];
                if (t == 8'd7) begin
                    if (k == 1) b = 8'h07;
                    else if (k == 57 || k == 64) b = h ? 8'h40 : 8'h00;
                    else if (k == 58 || k == 65) b = h ? 8'h00 : 8'h02;
                end
            end
            bt.d = b;
            bt.last = ((k % mps) == mps - 1) || (k == n - 1);
            bt.zlp = 1'b0;
            exp_q.push_back(bt);
        end
        if (n == 0 || ((n % mps) == 0 && n < int'(l))) begin
            bt.d = 8'h00; bt.last = 1'b1; bt.zlp = 1'b1;
            exp_q.push_back(bt);
        end
    endtask

    task automatic run_req(input bit s, input bit h, input logic [7:0] t, input logic [7:0] i,
                           input logic [15:0] l, input int rdy_pct, input int abort_after);
        bit exp_stall, fin, hold, abort_pending, aborted;
        int got, dones, stalls, stall_cyc, first_cyc, w;
        logic [7:0] pd;
        logic pl, pz;
        build_expect(s, h, t, i, l, exp_stall);
        @(negedge clk);
        sel = s; hs = h; req_type = t; req_index = i; req_length = l; req_valid = 1'b1;
        tx_ready = 1'b0;
        #1;
        w = 0;
        while (m_req_ready !== 1'b1 && w < 50) begin
            @(negedge clk); #1; w++;
        end
        chk("req_ready_before_accept", m_req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        got = 0; dones = 0; stalls = 0; stall_cyc = -1; first_cyc = -1;
        fin = 0; hold = 0; abort_pending = 0; aborted = 0;
        pd = '0; pl = 1'b0; pz = 1'b0;
        for (int cyc = 1; cyc <= 600 && !fin; cyc++) begin
            if (cyc > 1) @(negedge clk);
            tx_ready = ($urandom_range(99) < rdy_pct);
            if (abort_pending) begin
                abort = 1'b0;
                #1;
                chk("abort_valid_low", m_tx_valid, 0);
                chk("abort_req_ready", m_req_ready, 1);
                chk("abort_no_done", m_done, 0);
                aborted = 1; fin = 1;
            end else begin
                if (abort_after >= 0 && got == abort_after) begin
                    abort = 1'b1; abort_pending = 1;
                end
                #1;
                if (m_stall === 1'b1) begin stalls++; stall_cyc = cyc; fin = 1; end
                if (m_done === 1'b1) begin dones++; fin = 1; end
                if (m_tx_valid === 1'b1) begin
                    if (first_cyc < 0) first_cyc = cyc;
                    if (hold) begin
                        if (!pz) chk("hold_data", m_tx_data, pd);
                        chk("hold_last", m_tx_last, pl);
                        chk("hold_zlp", m_tx_zlp, pz);
                    end
                    if (tx_ready && !abort) begin
                        if (got < exp_q.size()) begin
                            if (!exp_q[got].zlp) chk($sformatf("data[%0d]", got), m_tx_data, exp_q[got].d);
                            chk($sformatf("last[%0d]", got), m_tx_last, exp_q[got].last);
                            chk($sformatf("zlp[%0d]", got), m_tx_zlp, exp_q[got].zlp);
                        end else begin
                            chk("extra_beat", 1, 0);
                        end
                        got++;
                        hold = 0;
                    end else begin
                        hold = 1; pd = m_tx_data; pl = m_tx_last; pz = m_tx_zlp;
                    end
                end else begin
                    hold = 0;
                end
            end
        end
        chk("terminated", fin, 1);
        abort = 1'b0;
        if (aborted) begin
            chk("abort_beats", got, abort_after);
            chk("abort_dones", dones, 0);
        end else if (exp_stall) begin
            chk("stall_count", stalls, 1);
            chk("stall_cycle", stall_cyc, 1);
            chk("stall_no_beats", got, 0);
            chk("stall_no_done", dones, 0);
        end else begin
            chk("beat_count", got, exp_q.size());
            chk("done_count", dones, 1);
            chk("no_stall", stalls, 0);
            chk("first_valid_latency", first_cyc, 2);
        end
        tx_ready = 1'b0;
        @(negedge clk); #1;
        chk("idle_valid", m_tx_valid, 0);
        chk("idle_done", m_done, 0);
        chk("idle_ready", m_req_ready, 1);
    endtask

    initial begin
        bit s, h;
        logic [7:0] t, i;
        logic [15:0] l;
        for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_tx_valid", a_tx_valid, 0);
        chk("rst_tx_last", a_tx_last, 0);
        chk("rst_tx_zlp", a_tx_zlp, 0);
        chk("rst_tx_data", a_tx_data, 0);
        chk("rst_rom_addr", a_rom_addr, 0);
        chk("rst_done", a_done, 0);
        chk("rst_stall", a_stall, 0);
        rst_n = 1'b1;

        run_req(0, 0, 8'd1, 8'd0, 16'd64, 100, -1);   // FS device: 8,8,2
        run_req(0, 1, 8'd2, 8'd0, 16'd9, 100, -1);    // HS config truncated to 9
        run_req(1, 0, 8'd3, 8'd0, 16'd255, 100, -1);  // MPS 2: 2,2 then ZLP
        run_req(1, 0, 8'd3, 8'd0, 16'd4, 100, -1);    // exact length: no ZLP
        run_req(0, 0, 8'h0F, 8'd0, 16'd64, 100, -1);  // unknown type
        run_req(0, 0, 8'd3, 8'd4, 16'd64, 100, -1);   // string index out of range
        run_req(0, 0, 8'd1, 8'd0, 16'd0, 100, -1);    // wLength 0: ZLP only
        run_req(0, 1, 8'd3, 8'd1, 16'd64, 50, -1);    // backpressure
        run_req(0, 1, 8'd3, 8'd1, 16'd64, 50, 5);     // abort after 5 bytes
        run_req(0, 0, 8'd6, 8'd0, 16'd64, 100, -1);   // qualifier or stall
        run_req(0, 1, 8'd7, 8'd0, 16'd100, 70, -1);   // other-speed config or stall

        for (int r = 0; r < 20; r++) begin
            s = 1'($urandom_range(1));
            h = 1'($urandom_range(1));
            i = 8'd0;
            case ($urandom_range(5))
                0: t = 8'd1;
                1: begin t = 8'd2; i = 8'($urandom_range(1)); end
                2: begin t = 8'd3; i = 8'($urandom_range(5)); end
                3: t = 8'd6;
                4: t = 8'd7;
                default: t = 8'($urandom_range(255));
            endcase
            case ($urandom_range(3))
                0: l = 16'd0;
                1: l = 16'($urandom_range(20, 1));
                2: l = 16'($urandom_range(80, 60));
                default: l = 16'($urandom);
            endcase
            run_req(s, h, t, i, l, $urandom_range(100, 30), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/usb_desc_engine.md
Name: usb_desc_engine

Overview:
- Sequential EP0 descriptor server for the USB bridge; successor to the combinational descriptor ROM.
- Accepts decoded GET_DESCRIPTOR requests, resolves type/index to a ROM window, and reads an external byte ROM.
- Streams bytes over a valid/ready interface, truncated to wLength and split into EP0 max-packet-size packets, with zero-length-packet (ZLP) insertion.
- Sits between the setup decoder and the EP0 IN transmit path.

Parameters:
- ROM_AW, 8, ROM address width in bits.
- NUM_STRINGS, 4, number of string descriptors served (index 0 = LANGID); string index >= NUM_STRINGS stalls.
- EP0_MPS_FS, 8, EP0 packet size in full-speed mode, 1..64.
- EP0_MPS_HS, 64, EP0 packet size in high-speed mode, 1..64.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-low reset.
- hs_i  in  1  high-speed mode; sampled at request accept.
- req_valid_i  in  1  request strobe.
- req_ready_o  out  1  high only in IDLE.
- req_type_i  in  8  wValue[15:8], descriptor type.
- req_index_i  in  8  wValue[7:0], descriptor index.
- req_length_i  in  16  wLength.
- abort_i  in  1  new SETUP or bus reset; cancels the transfer.
- rom_addr_o  out  ROM_AW  ROM byte address; ROM read is combinational.
- rom_data_i  in  8  ROM byte.
- tx_data_o  out  8  stream byte.
- tx_valid_o  out  1  stream valid.
- tx_last_o  out  1  last byte of packet; also set with tx_zlp_o.
- tx_zlp_o  out  1  zero-length-packet beat; tx_data_o is don't-care.
- tx_ready_i  in  1  sink accept.
- done_o  out  1  one-cycle pulse after the final packet is accepted.
- stall_o  out  1  one-cycle pulse for an unsupported request.

Behaviour:
- Reset (rst_i == 0 at a clock edge): state IDLE. All outputs 0 except req_ready_o = 1. Reset overrides everything mid-transfer.

States and transitions:
- IDLE: a cycle with req_valid_i && req_ready_o is an accept. On accept, latch type, index, length, and hs_i as mps = hs ? EP0_MPS_HS : EP0_MPS_FS. Go to LOOKUP.
- LOOKUP, one cycle: resolve {base, dlen} from the package table.
  - Unsupported type/index: pulse stall_o, go to IDLE.
  - Otherwise: remain = min(length, dlen) (16-bit compare). Set rom_addr_o = base, pkt_cnt = 0.
  - remain == 0 (wLength 0): go to ZLP. Otherwise go to STREAM.
- STREAM:
  - tx_valid_o = 1, tx_data_o = rom_data_i.
  - tx_last_o = (pkt_cnt == mps-1) || (remain == 1).
  - On each handshake (tx_valid_o && tx_ready_i): rom_addr_o++, remain--, pkt_cnt wraps to 0 when tx_last_o.
  - After the final byte: go to ZLP when the sent total == min(...) is a nonzero multiple of mps AND total < wLength; otherwise go to DONE.
- ZLP: tx_valid_o = tx_last_o = tx_zlp_o = 1. On handshake go to DONE.
- DONE: pulse done_o, go to IDLE.

Timing and handshake rules:
- First byte is valid 2 cycles after the accept edge.
- Full throughput is 1 byte/cycle.
- While tx_valid_o && !tx_ready_i, tx_data_o, tx_last_o and tx_zlp_o hold stable.
- abort_i in any state: go to IDLE next cycle; tx_valid_o drops, no done_o/stall_o. abort_i takes priority over a same-cycle handshake, and that byte counts as not sent.
- A req_valid_i while not in IDLE is ignored; the producer holds it.

Descriptor table (ROM layout):
- Device: type 1, base 0, len 18.
- Config: type 2, index 0, base 18, len 67.
- String: type 3, indices 0..3, bases 85/89/119/149, lens 4/30/30/14.
- Any other type or index stalls.

Optional Feature:
- USB_DESC_QUALIFIER_EN.
- Defined:
  - Type 6 (device qualifier): serves a synthesized 10-byte descriptor from an internal constant. Bytes 0–5 are 0A 06 00 02 02 00, byte 6 = 00, byte 7 = other-speed MPS (FS value when hs, else HS value), byte 8 = 01, byte 9 = 00. Byte 6 is bDeviceProtocol, a constant 00; bMaxPacketSize0 is byte 7.
  - Type 7 (other-speed config): serves config window 18..84 with byte 1 forced to 07 and the bulk wMaxPacketSize fields (ROM offsets 75/76, 82/83) swapped to the other speed.
- Undefined: types 6 and 7 stall.

Decomposition:
- Package usb_desc_pkg holds:
  - descriptor type constants;
  - base/length table constants;
  - the state enum (IDLE, LOOKUP, STREAM, ZLP, DONE);
  - the qualifier byte constants.
- One natural sub-module: usb_desc_lookup, combinational type/index/hs to {base, dlen, supported, patch selects}.

Test Plan:
- FS, device type 1, wLength 64 -> 18 bytes, ROM 0..17 in order; packets 8,8,2; tx_last_o on bytes 8, 16, 18; no ZLP; done_o once.
- HS, config, wLength 9 -> 9 bytes (ROM 18..26), single packet; tx_last_o on byte 9.
- EP0_MPS_FS=2, FS, string 0, wLength 255 -> packets 2,2 then ZLP beat (tx_zlp_o=1), then done_o. Repeat with wLength 4 -> no ZLP.
- Type 0x0F, string index 4, and wLength 0 on device -> stall, stall, ZLP-only; no data beats for any of them.
- HS string 1, tx_ready_i random 50% -> 30 bytes intact with stable data under backpressure. Second run: abort_i after byte 5 -> tx_valid_o low next cycle, req_ready_o high, no done_o.
- Macro defined, FS, type 6 -> 0A 06 00 02 02 00 00 40 01 00. Macro undefined, type 6 -> stall_o.
